// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data
// stages, one access at a time, with a fixed-latency wait counter.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_valid,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_valid,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  stall_f,
   output logic                  stall_m
);
   localparam int CW = $clog2(MEM_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          gnt_d;
   logic          pick_d;
   logic          pick_i;
   logic          last_cyc;
   logic          grant;
   logic          load_cnt;
   logic          capture;

   // gnt_d doubles as last_grant: a tie goes to the port not served last
   assign pick_d   = d_req & (~if_req | ~gnt_d);
   assign pick_i   = if_req & ~pick_d;
   assign last_cyc = (cnt == CW'(1));

   assign stall_f = if_req & ~if_valid;
   assign stall_m = d_req & ~d_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (pick_d | pick_i) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (last_cyc) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant    = 1'b0;
      load_cnt = 1'b0;
      capture  = 1'b0;
      unique case (state)
         IDLE:    grant    = pick_d | pick_i;
         ISSUE:   load_cnt = 1'b1;
         WAIT:    capture  = last_cyc;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         gnt_d     <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_valid  <= 1'b0;
         d_valid   <= 1'b0;
      end else begin
         mem_en   <= grant;
         if_valid <= capture & ~gnt_d;
         d_valid  <= capture & gnt_d;
         if (grant) begin
            gnt_d    <= pick_d;
            mem_we   <= pick_d & d_we;
            mem_addr <= pick_d ? d_addr : if_addr;
            if (pick_d) mem_wdata <= d_wdata;
         end
         if (load_cnt)           cnt <= CW'(MEM_LATENCY);
         else if (state == WAIT) cnt <= cnt - 1'b1;
         // stores leave both read-data registers untouched
         if (capture && !mem_we) begin
            if (gnt_d) d_rdata  <= mem_rdata;
            else       if_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand sequences
// for arbitration order, reset mid-access and latency 1.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_valid, d_valid, mem_en, mem_we, stall_f, stall_m;

   logic        if_req2, d_req2, d_we2;
   logic [31:0] if_addr2, d_addr2, d_wdata2, mem_rdata2;
   logic [31:0] if_rdata2, d_rdata2, mem_addr2, mem_wdata2;
   logic        if_valid2, d_valid2, mem_en2, mem_we2, stall_f2, stall_m2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stall_f(stall_f), .stall_m(stall_m)
   );

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut2 (
      .clk(clk), .rst(rst),
      .if_req(if_req2), .if_addr(if_addr2), .if_rdata(if_rdata2), .if_valid(if_valid2),
      .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
      .d_rdata(d_rdata2), .d_valid(d_valid2),
      .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
      .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
      .stall_f(stall_f2), .stall_m(stall_m2)
   );

   typedef struct {
      logic ireq; logic [31:0] iaddr;
      logic dreq; logic dwe; logic [31:0] daddr; logic [31:0] dwd;
      logic [31:0] mrd;
      logic en; logic we; logic [31:0] ma; logic [31:0] mw;
      logic iv; logic [31:0] ird;
      logic dv; logic [31:0] drd;
      logic sf; logic sm;
   } vec_t;

   vec_t v[16];

   int          en_c[$];
   logic [31:0] en_a[$];
   int          iv_c[$];
   logic [31:0] iv_d[$];
   int          dv_c[$];
   logic [31:0] dv_d[$];

   function automatic vec_t mk(
      logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
      logic [31:0] wd, logic [31:0] rd, logic en, logic we, logic [31:0] ma,
      logic [31:0] mw, logic iv, logic [31:0] ird, logic dv, logic [31:0] drd,
      logic sf, logic sm);
      vec_t r;
      r.ireq = ir; r.iaddr = ia; r.dreq = dr; r.dwe = dw; r.daddr = da;
      r.dwd = wd; r.mrd = rd; r.en = en; r.we = we; r.ma = ma; r.mw = mw;
      r.iv = iv; r.ird = ird; r.dv = dv; r.drd = drd; r.sf = sf; r.sm = sm;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, exp);
      end
   endtask

   task automatic clear_q();
      en_c.delete(); en_a.delete(); iv_c.delete();
      iv_d.delete(); dv_c.delete(); dv_d.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      chk("rst.mem_en", mem_en, 0);
      chk("rst.mem_we", mem_we, 0);
      chk("rst.mem_addr", mem_addr, 0);
      chk("rst.mem_wdata", mem_wdata, 0);
      chk("rst.if_rdata", if_rdata, 0);
      chk("rst.d_rdata", d_rdata, 0);
      chk("rst.if_valid", if_valid, 0);
      chk("rst.d_valid", d_valid, 0);
      rst = 1'b0;
   endtask

   // adv=1: present a fresh address on valid; adv=0: drop the request
   task automatic run(input int n, input bit adv);
      for (int c = 0; c < n; c++) begin
         mem_rdata = 32'hA000_0000 | c;
         @(negedge clk);
         if (mem_en) begin en_c.push_back(c); en_a.push_back(mem_addr); end
         if (if_valid) begin
            iv_c.push_back(c); iv_d.push_back(if_rdata);
            if (adv) if_addr = if_addr + 4; else if_req = 0;
         end
         if (d_valid) begin
            dv_c.push_back(c); dv_d.push_back(d_rdata);
            if (adv) d_addr = d_addr + 4; else d_req = 0;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      automatic logic [31:0] f  = 32'hFFFF_FFFF;
      automatic logic [31:0] i0 = 32'h0050_0093;
      automatic logic [31:0] cf = 32'hCAFE_F00D;
      automatic logic [31:0] db = 32'hDEAD_BEEF;
      automatic int          ec[4] = '{1, 6, 11, 16};
      automatic logic [31:0] ea[4] = '{32'h300, 32'h200, 32'h304, 32'h204};

      if_req2 = 0; if_addr2 = 0; d_req2 = 0; d_we2 = 0;
      d_addr2 = 0; d_wdata2 = 0; mem_rdata2 = 32'hFFFF_FFFF;

      // fetch 0x10, load 0x80, store 0x100, idle
      v[0]  = mk(1,'h10, 0,0,0,0, f,  0,0,0,0,       0,0,  0,0,  1,0);
      v[1]  = mk(1,'h10, 0,0,0,0, f,  1,0,'h10,0,    0,0,  0,0,  1,0);
      v[2]  = mk(1,'h10, 0,0,0,0, f,  0,0,'h10,0,    0,0,  0,0,  1,0);
      v[3]  = mk(1,'h10, 0,0,0,0, i0, 0,0,'h10,0,    0,0,  0,0,  1,0);
      v[4]  = mk(1,'h10, 0,0,0,0, f,  0,0,'h10,0,    1,i0, 0,0,  0,0);
      v[5]  = mk(0,0, 1,0,'h80,0, f,  0,0,'h10,0,    0,i0, 0,0,  0,1);
      v[6]  = mk(0,0, 1,0,'h80,0, f,  1,0,'h80,0,    0,i0, 0,0,  0,1);
      v[7]  = mk(0,0, 1,0,'h80,0, f,  0,0,'h80,0,    0,i0, 0,0,  0,1);
      v[8]  = mk(0,0, 1,0,'h80,0, cf, 0,0,'h80,0,    0,i0, 0,0,  0,1);
      v[9]  = mk(0,0, 1,0,'h80,0, f,  0,0,'h80,0,    0,i0, 1,cf, 0,0);
      v[10] = mk(0,0, 1,1,'h100,db, f, 0,0,'h80,0,   0,i0, 0,cf, 0,1);
      v[11] = mk(0,0, 1,1,'h100,db, f, 1,1,'h100,db, 0,i0, 0,cf, 0,1);
      v[12] = mk(0,0, 1,1,'h100,db, f, 0,1,'h100,db, 0,i0, 0,cf, 0,1);
      v[13] = mk(0,0, 1,1,'h100,db, 32'h1111_1111, 0,1,'h100,db, 0,i0, 0,cf, 0,1);
      v[14] = mk(0,0, 1,1,'h100,db, f, 0,1,'h100,db, 0,i0, 1,cf, 0,0);
      v[15] = mk(0,0, 0,0,0,0,      f, 0,1,'h100,db, 0,i0, 0,cf, 0,0);

      do_reset();

      for (int i = 0; i < 16; i++) begin
         if_req = v[i].ireq; if_addr = v[i].iaddr;
         d_req = v[i].dreq; d_we = v[i].dwe;
         d_addr = v[i].daddr; d_wdata = v[i].dwd; mem_rdata = v[i].mrd;
         @(negedge clk);
         chk($sformatf("v%0d.mem_en", i), mem_en, v[i].en);
         chk($sformatf("v%0d.mem_we", i), mem_we, v[i].we);
         chk($sformatf("v%0d.mem_addr", i), mem_addr, v[i].ma);
         chk($sformatf("v%0d.mem_wdata", i), mem_wdata, v[i].mw);
         chk($sformatf("v%0d.if_valid", i), if_valid, v[i].iv);
         chk($sformatf("v%0d.if_rdata", i), if_rdata, v[i].ird);
         chk($sformatf("v%0d.d_valid", i), d_valid, v[i].dv);
         chk($sformatf("v%0d.d_rdata", i), d_rdata, v[i].drd);
         chk($sformatf("v%0d.stall_f", i), stall_f, v[i].sf);
         chk($sformatf("v%0d.stall_m", i), stall_m, v[i].sm);
         @(posedge clk); #1;
      end

      // tie after reset, both held: D, I, D, I every 5 cycles
      do_reset();
      clear_q();
      if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h300;
      run(20, 1'b1);
      if_req = 0; d_req = 0;
      chk("rr.n_en", en_c.size(), 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr.en_cyc%0d", k), (k < en_c.size()) ? en_c[k] : -1, ec[k]);
         chk($sformatf("rr.en_addr%0d", k), (k < en_a.size()) ? en_a[k] : 0, ea[k]);
      end
      chk("rr.n_iv", iv_c.size(), 2);
      chk("rr.n_dv", dv_c.size(), 2);
      chk("rr.dv_cyc0", (dv_c.size() > 0) ? dv_c[0] : -1, 4);
      chk("rr.dv_dat0", (dv_d.size() > 0) ? dv_d[0] : 0, 32'hA000_0003);
      chk("rr.iv_cyc0", (iv_c.size() > 0) ? iv_c[0] : -1, 9);
      chk("rr.iv_dat0", (iv_d.size() > 0) ? iv_d[0] : 0, 32'hA000_0008);
      chk("rr.dv_cyc1", (dv_c.size() > 1) ? dv_c[1] : -1, 14);
      chk("rr.dv_dat1", (dv_d.size() > 1) ? dv_d[1] : 0, 32'hA000_000D);
      chk("rr.iv_cyc1", (iv_c.size() > 1) ? iv_c[1] : -1, 19);
      chk("rr.iv_dat1", (iv_d.size() > 1) ? iv_d[1] : 0, 32'hA000_0012);

      // reset during WAIT of a load, then a clean load to 0x20
      clear_q();
      d_req = 1; d_we = 0; d_addr = 32'h60;
      run(2, 1'b0);
      chk("rm.pre_en", en_c.size(), 1);
      rst = 1'b1;
      #1;
      chk("rm.mem_en", mem_en, 0);
      chk("rm.mem_addr", mem_addr, 0);
      chk("rm.mem_we", mem_we, 0);
      chk("rm.mem_wdata", mem_wdata, 0);
      chk("rm.if_rdata", if_rdata, 0);
      chk("rm.d_rdata", d_rdata, 0);
      chk("rm.if_valid", if_valid, 0);
      chk("rm.d_valid", d_valid, 0);
      d_addr = 32'h20;
      @(negedge clk);
      chk("rm.hold_dv", d_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      clear_q();
      run(7, 1'b0);
      chk("rm.n_en", en_c.size(), 1);
      chk("rm.en_cyc", (en_c.size() > 0) ? en_c[0] : -1, 1);
      chk("rm.en_addr", (en_a.size() > 0) ? en_a[0] : 0, 32'h20);
      chk("rm.n_dv", dv_c.size(), 1);
      chk("rm.dv_cyc", (dv_c.size() > 0) ? dv_c[0] : -1, 4);
      chk("rm.dv_dat", (dv_d.size() > 0) ? dv_d[0] : 0, 32'hA000_0003);

      // latency 1: data only valid in the capture cycle
      d_req2 = 1; d_we2 = 0; d_addr2 = 32'h40;
      for (int c = 0; c < 6; c++) begin
         mem_rdata2 = (c == 2) ? 32'h1234_5678 : 32'hFFFF_FFFF;
         @(negedge clk);
         chk($sformatf("l1.mem_en%0d", c), mem_en2, (c == 1));
         chk($sformatf("l1.d_valid%0d", c), d_valid2, (c == 3));
         chk($sformatf("l1.if_valid%0d", c), if_valid2, 0);
         if (c == 0) chk("l1.stall_m", stall_m2, 1);
         if (c == 1) chk("l1.mem_addr", mem_addr2, 32'h40);
         if (c == 3) begin
            chk("l1.d_rdata", d_rdata2, 32'h1234_5678);
            d_req2 = 0;
         end
         @(posedge clk); #1;
      end
      chk("l1.mem_we", mem_we2, 0);
      chk("l1.mem_wdata", mem_wdata2, 0);
      chk("l1.if_rdata", if_rdata2, 0);
      chk("l1.stall_f", stall_f2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
